// File: rtl/core_exec_array.sv
// Bank of execution slots behind the scheduler dispatch port.
// Slots count down task durations and retire through a round-robin completion port.
module core_exec_array #(
  parameter int NUM_CORES = 4,
  parameter int DUR_W     = 8,
  parameter int TAG_W     = 4,
  parameter int PRIO_W    = 3,
  localparam int IDX_W    = $clog2(NUM_CORES)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [PRIO_W-1:0]          disp_priority,
  input  logic [DUR_W-1:0]           disp_duration,
  input  logic [TAG_W-1:0]           disp_tag,
  output logic [IDX_W-1:0]           disp_core,
  output logic [NUM_CORES-1:0]       core_busy,
  output logic [NUM_CORES*DUR_W-1:0] core_remaining,
  output logic                       cmp_valid,
  input  logic                       cmp_ready,
  output logic [IDX_W-1:0]           cmp_core,
  output logic [TAG_W-1:0]           cmp_tag,
  output logic [PRIO_W-1:0]          cmp_priority,
  output logic [15:0]                done_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } slot_st_t;

  slot_st_t          st_q   [NUM_CORES];
  logic [DUR_W-1:0]  rem_q  [NUM_CORES];
  logic [TAG_W-1:0]  tag_q  [NUM_CORES];
  logic [PRIO_W-1:0] prio_q [NUM_CORES];

  logic [IDX_W-1:0]     rr_q;
  logic [IDX_W-1:0]     grant_q;
  logic                 lock_q;
  logic [IDX_W-1:0]     search;
  logic                 found;
  logic [IDX_W-1:0]     grant;
  logic [NUM_CORES-1:0] idle_v;
  logic [NUM_CORES-1:0] done_v;
  logic [DUR_W-1:0]     dur_eff;
  logic                 disp_fire;
  logic                 cmp_fire;

  always_comb begin
    idle_v         = '0;
    done_v         = '0;
    core_remaining = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idle_v[i] = (st_q[i] == S_IDLE);
      done_v[i] = (st_q[i] == S_DONE);
      core_remaining[i*DUR_W +: DUR_W] = rem_q[i];
    end
  end

  always_comb begin
    disp_core = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (idle_v[i]) disp_core = IDX_W'(i);
    end
  end

  always_comb begin
    search = rr_q;
    found  = 1'b0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (!found && done_v[(int'(rr_q) + k) % NUM_CORES]) begin
        search = IDX_W'((int'(rr_q) + k) % NUM_CORES);
        found  = 1'b1;
      end
    end
  end

  // A stalled record is pinned so a later DONE slot cannot steal the grant.
  assign grant        = lock_q ? grant_q : search;
  assign disp_ready   = |idle_v;
  assign core_busy    = ~idle_v;
  assign cmp_valid    = |done_v;
  assign cmp_core     = grant;
  assign cmp_tag      = tag_q[grant];
  assign cmp_priority = prio_q[grant];
  assign disp_fire    = disp_valid && disp_ready;
  assign cmp_fire     = cmp_valid && cmp_ready;
  assign dur_eff      = (disp_duration == '0) ? DUR_W'(1) : disp_duration;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        st_q[i]   <= S_IDLE;
        rem_q[i]  <= '0;
        tag_q[i]  <= '0;
        prio_q[i] <= '0;
      end
      rr_q       <= '0;
      grant_q    <= '0;
      lock_q     <= 1'b0;
      done_count <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        case (st_q[i])
          S_IDLE: begin
            if (disp_fire && disp_core == IDX_W'(i)) begin
              st_q[i]   <= S_RUN;
              rem_q[i]  <= dur_eff;
              tag_q[i]  <= disp_tag;
              prio_q[i] <= disp_priority;
            end
          end
          S_RUN: begin
            if (rem_q[i] == DUR_W'(1)) begin
              st_q[i]  <= S_DONE;
              rem_q[i] <= '0;
            end else begin
              rem_q[i] <= rem_q[i] - DUR_W'(1);
            end
          end
          S_DONE: begin
            if (cmp_fire && grant == IDX_W'(i)) st_q[i] <= S_IDLE;
          end
          default: st_q[i] <= S_IDLE;
        endcase
      end
      lock_q  <= cmp_valid && !cmp_ready;
      grant_q <= grant;
      if (cmp_fire) begin
        rr_q <= (grant == IDX_W'(NUM_CORES - 1)) ? '0 : grant + IDX_W'(1);
        done_count <= done_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_core_exec_array.sv
// Scoreboard bench for core_exec_array: dispatch, countdown,
// round-robin completion, back-pressure and asynchronous reset.
module tb_core_exec_array;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TW = 4;
  localparam int PW = 3;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          disp_valid = 1'b0;
  logic          disp_ready;
  logic [PW-1:0] disp_priority = '0;
  logic [DW-1:0] disp_duration = '0;
  logic [TW-1:0] disp_tag = '0;
  logic [IW-1:0] disp_core;
  logic [N-1:0]  core_busy;
  logic [N*DW-1:0] core_remaining;
  logic          cmp_valid;
  logic          cmp_ready = 1'b0;
  logic [IW-1:0] cmp_core;
  logic [TW-1:0] cmp_tag;
  logic [PW-1:0] cmp_priority;
  logic [15:0]   done_count;

  typedef struct packed {
    logic [IW-1:0] core;
    logic [TW-1:0] tag;
    logic [PW-1:0] prio;
  } rec_t;

  rec_t sb[$];
  rec_t mon_got;
  rec_t mon_exp;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_done = 0;

  core_exec_array #(
    .NUM_CORES(N), .DUR_W(DW), .TAG_W(TW), .PRIO_W(PW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .disp_valid(disp_valid),
    .disp_ready(disp_ready),
    .disp_priority(disp_priority),
    .disp_duration(disp_duration),
    .disp_tag(disp_tag),
    .disp_core(disp_core),
    .core_busy(core_busy),
    .core_remaining(core_remaining),
    .cmp_valid(cmp_valid),
    .cmp_ready(cmp_ready),
    .cmp_core(cmp_core),
    .cmp_tag(cmp_tag),
    .cmp_priority(cmp_priority),
    .done_count(done_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // Completion records are checked against the scoreboard in handshake order.
  always @(negedge clk) begin
    if (!reset && cmp_valid && cmp_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL cmp_unexpected core=%0d tag=%0d prio=%0d",
                 cmp_core, cmp_tag, cmp_priority);
      end else begin
        mon_exp = sb.pop_front();
        mon_got = {cmp_core, cmp_tag, cmp_priority};
        if (mon_got !== mon_exp) begin
          n_bad++;
          $display("FAIL cmp_record got core=%0d tag=%0d prio=%0d want core=%0d tag=%0d prio=%0d",
                   mon_got.core, mon_got.tag, mon_got.prio,
                   mon_exp.core, mon_exp.tag, mon_exp.prio);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rec(input int core, input int tag, input int prio);
    rec_t r;
    r.core = IW'(core);
    r.tag  = TW'(tag);
    r.prio = PW'(prio);
    sb.push_back(r);
    exp_done++;
  endtask

  task automatic drive_dispatch(input int dur, input int tag,
                                input int prio, input int exp_core);
    disp_valid    = 1'b1;
    disp_duration = DW'(dur);
    disp_tag      = TW'(tag);
    disp_priority = PW'(prio);
    n_cmp++;
    if (disp_ready !== 1'b1 || disp_core !== IW'(exp_core)) begin
      n_bad++;
      $display("FAIL dispatch_sel ready=%0b core=%0d want ready=1 core=%0d",
               disp_ready, disp_core, exp_core);
    end
    step();
    disp_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_cmp++;
    if (disp_ready !== 1'b1 || cmp_valid !== 1'b0 || core_busy !== '0 ||
        done_count !== 16'd0 || core_remaining !== '0) begin
      n_bad++;
      $display("FAIL reset_state ready=%0b cvalid=%0b busy=%h cnt=%0d rem=%h want 1 0 0 0 0",
               disp_ready, cmp_valid, core_busy, done_count, core_remaining);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    cmp_ready = 1'b1;
    expect_rec(0, 5, 2);
    drive_dispatch(3, 5, 2, 0);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (core_remaining[7:0] !== DW'(3 - k) || cmp_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL basic_countdown rem=%0d cvalid=%0b want rem=%0d cvalid=0",
                 core_remaining[7:0], cmp_valid, 3 - k);
      end
      step();
    end
    n_cmp++;
    if (cmp_valid !== 1'b1 || cmp_core !== 2'd0) begin
      n_bad++;
      $display("FAIL basic_latency cvalid=%0b core=%0d want 1 0", cmp_valid, cmp_core);
    end
    step();
    n_cmp++;
    if (core_busy !== 4'b0000 || done_count !== 16'(exp_done)) begin
      n_bad++;
      $display("FAIL basic_retire busy=%b cnt=%0d want 0000 %0d",
               core_busy, done_count, exp_done);
    end
  endtask

  task automatic test_zero_dur();
    expect_rec(0, 1, 4);
    drive_dispatch(0, 1, 4, 0);
    n_cmp++;
    if (core_remaining[7:0] !== 8'd1 || cmp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_dur_load rem=%0d cvalid=%0b want 1 0",
               core_remaining[7:0], cmp_valid);
    end
    step();
    n_cmp++;
    if (cmp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL zero_dur_done cvalid=%0b want 1", cmp_valid);
    end
    step();
    n_cmp++;
    if (core_busy !== 4'b0000 || done_count !== 16'(exp_done)) begin
      n_bad++;
      $display("FAIL zero_dur_retire busy=%b cnt=%0d want 0000 %0d",
               core_busy, done_count, exp_done);
    end
  endtask

  task automatic test_full();
    int waited;
    bit taken;
    cmp_ready = 1'b1;
    for (int c = 0; c < 4; c++) expect_rec(c, 8 + c, c);
    for (int c = 0; c < 4; c++) drive_dispatch(10, 8 + c, c, c);
    disp_valid    = 1'b1;
    disp_duration = 8'd2;
    disp_tag      = 4'd12;
    disp_priority = 3'd5;
    n_cmp++;
    if (disp_ready !== 1'b0 || core_busy !== 4'b1111) begin
      n_bad++;
      $display("FAIL full_ready ready=%0b busy=%b want 0 1111", disp_ready, core_busy);
    end
    waited = 0;
    taken  = 1'b0;
    for (int c = 0; c < 30 && !taken; c++) begin
      if (disp_ready) begin
        n_cmp++;
        if (disp_core !== 2'd0 || waited !== 8) begin
          n_bad++;
          $display("FAIL full_reuse core=%0d wait=%0d want 0 8", disp_core, waited);
        end
        expect_rec(0, 12, 5);
        step();
        disp_valid = 1'b0;
        taken = 1'b1;
      end else begin
        step();
        waited++;
      end
    end
    disp_valid = 1'b0;
    n_cmp++;
    if (!taken) begin
      n_bad++;
      $display("FAIL full_reuse_timeout taken=0 want 1");
    end
    for (int c = 0; c < 40 && sb.size() != 0; c++) step();
    n_cmp++;
    if (sb.size() != 0 || done_count !== 16'(exp_done) || core_busy !== '0) begin
      n_bad++;
      $display("FAIL full_drain left=%0d cnt=%0d busy=%b want 0 %0d 0000",
               sb.size(), done_count, core_busy, exp_done);
    end
  endtask

  task automatic test_rr_order();
    int ord[4] = '{2, 3, 0, 1};
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb.delete();
    exp_done  = 0;
    cmp_ready = 1'b1;
    for (int c = 0; c < 4; c++) expect_rec(c, c + 1, c);
    for (int c = 0; c < 4; c++) drive_dispatch(4 - c, c + 1, c, c);
    step();
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (cmp_valid !== 1'b1 || cmp_core !== IW'(c)) begin
        n_bad++;
        $display("FAIL rr_from0 slot%0d cvalid=%0b core=%0d want 1 %0d",
                 c, cmp_valid, cmp_core, c);
      end
      step();
    end
    n_cmp++;
    if (done_count !== 16'(exp_done) || cmp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rr_from0_cnt cnt=%0d cvalid=%0b want %0d 0",
               done_count, cmp_valid, exp_done);
    end
    expect_rec(1, 6, 1);
    expect_rec(2, 8, 3);
    expect_rec(3, 9, 4);
    expect_rec(0, 13, 0);
    expect_rec(1, 7, 2);
    drive_dispatch(10, 13, 0, 0);
    drive_dispatch(1, 6, 1, 1);
    step();
    step();
    drive_dispatch(6, 7, 2, 1);
    drive_dispatch(5, 8, 3, 2);
    drive_dispatch(4, 9, 4, 3);
    for (int c = 0; c < 4; c++) step();
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (cmp_valid !== 1'b1 || cmp_core !== IW'(ord[c])) begin
        n_bad++;
        $display("FAIL rr_from2 pos%0d cvalid=%0b core=%0d want 1 %0d",
                 c, cmp_valid, cmp_core, ord[c]);
      end
      step();
    end
    n_cmp++;
    if (done_count !== 16'(exp_done) || sb.size() != 0) begin
      n_bad++;
      $display("FAIL rr_from2_cnt cnt=%0d left=%0d want %0d 0",
               done_count, sb.size(), exp_done);
    end
  endtask

  task automatic test_backpressure();
    cmp_ready = 1'b0;
    expect_rec(1, 6, 3);
    expect_rec(2, 7, 7);
    expect_rec(0, 10, 1);
    drive_dispatch(20, 10, 1, 0);
    drive_dispatch(1, 6, 3, 1);
    drive_dispatch(3, 7, 7, 2);
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (cmp_valid !== 1'b1 || cmp_core !== 2'd1 || cmp_tag !== 4'd6 ||
          cmp_priority !== 3'd3 || done_count !== 16'(exp_done - 3)) begin
        n_bad++;
        $display("FAIL bp_hold cyc%0d cvalid=%0b core=%0d tag=%0d prio=%0d cnt=%0d want 1 1 6 3 %0d",
                 c, cmp_valid, cmp_core, cmp_tag, cmp_priority, done_count, exp_done - 3);
      end
      step();
    end
    n_cmp++;
    if (core_busy[2] !== 1'b1 || core_remaining[23:16] !== 8'd0 || cmp_core !== 2'd1) begin
      n_bad++;
      $display("FAIL bp_slot2_done busy2=%0b rem2=%0d core=%0d want 1 0 1",
               core_busy[2], core_remaining[23:16], cmp_core);
    end
    cmp_ready = 1'b1;
    for (int c = 0; c < 40 && sb.size() != 0; c++) step();
    n_cmp++;
    if (sb.size() != 0 || done_count !== 16'(exp_done) || core_busy !== '0) begin
      n_bad++;
      $display("FAIL bp_drain left=%0d cnt=%0d busy=%b want 0 %0d 0000",
               sb.size(), done_count, core_busy, exp_done);
    end
  endtask

  task automatic test_reset_mid();
    cmp_ready = 1'b0;
    drive_dispatch(1, 3, 3, 0);
    drive_dispatch(20, 4, 4, 1);
    drive_dispatch(20, 5, 5, 2);
    n_cmp++;
    if (cmp_valid !== 1'b1 || core_busy !== 4'b0111 || done_count === 16'd0) begin
      n_bad++;
      $display("FAIL rmid_pre cvalid=%0b busy=%b cnt=%0d want 1 0111 nonzero",
               cmp_valid, core_busy, done_count);
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (cmp_valid !== 1'b0 || core_busy !== '0 || done_count !== 16'd0 ||
        disp_ready !== 1'b1 || core_remaining !== '0) begin
      n_bad++;
      $display("FAIL rmid_async cvalid=%0b busy=%b cnt=%0d ready=%0b rem=%h want 0 0 0 1 0",
               cmp_valid, core_busy, done_count, disp_ready, core_remaining);
    end
    @(posedge clk);
    #3;
    reset = 1'b0;
    sb.delete();
    exp_done  = 0;
    cmp_ready = 1'b1;
    for (int c = 0; c < 25; c++) step();
    n_cmp++;
    if (cmp_valid !== 1'b0 || done_count !== 16'd0 || core_busy !== '0) begin
      n_bad++;
      $display("FAIL rmid_stale cvalid=%0b cnt=%0d busy=%b want 0 0 0",
               cmp_valid, done_count, core_busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_dur();
    test_full();
    test_rr_order();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/core_exec_array.md
Name: core_exec_array

Overview:
- Responder end of the scheduler-to-core dispatch interface: a bank of NUM_CORES execution slots.
- Each slot accepts one dispatched task descriptor and counts down its duration.
- On finish, each slot reports completion through a back-pressurable, round-robin-arbitrated completion channel.
- Sits directly downstream of the priority scheduler; its completions feed retirement and statistics logic.

Parameters:
- NUM_CORES, 4, number of execution slots (2..8).
- DUR_W, 8, task duration width in cycles.
- TAG_W, 4, task identifier width.
- PRIO_W, 3, task priority width.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- disp_valid  input  1  dispatch descriptor valid.
- disp_ready  output  1  at least one slot IDLE.
- disp_priority  input  PRIO_W  priority of dispatched task.
- disp_duration  input  DUR_W  execution cycles; 0 is treated as 1.
- disp_tag  input  TAG_W  task identifier.
- disp_core  output  clog2(NUM_CORES)  slot that takes the descriptor if the handshake fires this cycle.
- core_busy  output  NUM_CORES  bit i = slot i is RUN or DONE.
- core_remaining  output  NUM_CORES*DUR_W  remaining cycles per slot, slot i at [i*DUR_W +: DUR_W].
- cmp_valid  output  1  completion record valid.
- cmp_ready  input  1  completion consumer ready.
- cmp_core  output  clog2(NUM_CORES)  slot reporting completion.
- cmp_tag  output  TAG_W  tag of completed task.
- cmp_priority  output  PRIO_W  priority of completed task.
- done_count  output  16  total completions accepted; wraps at 65535->0.

Behaviour:
- Reset (async, active-high):
  - All slots IDLE; remaining=0; stored tag/priority=0.
  - RR pointer=0; done_count=0.
  - Outputs: disp_ready=1 (derived), cmp_valid=0, core_busy=0.
  - Reset mid-operation discards all running and DONE tasks; no completion is reported for them.
- Per-slot FSM (registered): IDLE, RUN, DONE.
  - IDLE->RUN on dispatch handshake (disp_valid&&disp_ready) when the slot is the selected disp_core. Latches remaining=max(disp_duration,1), tag, priority.
  - RUN: remaining decrements by 1 each cycle. When remaining==1 at a clock edge, go to DONE with remaining=0. A slot therefore spends exactly max(d,1) cycles in RUN.
  - DONE: holds tag/priority until its completion handshake; then -> IDLE next edge.
- Dispatch side:
  - disp_ready = OR of slot IDLE flags, combinational from registered state only, never from disp_valid.
  - disp_core = lowest-index IDLE slot; don't-care (drive 0) when none is IDLE.
  - A slot leaving DONE in cycle T becomes dispatchable in cycle T+1, never in T.
  - Descriptor inputs are sampled only on the handshake edge.
- Completion side:
  - cmp_valid = any slot DONE.
  - Grant = first DONE slot at or after the RR pointer, searching upward with wrap.
  - cmp_core/cmp_tag/cmp_priority show the granted slot.
  - On cmp_valid&&cmp_ready: granted slot -> IDLE; pointer = (grant+1) mod NUM_CORES; done_count += 1.
  - While cmp_ready=0, the record and grant stay stable. A higher-priority slot reaching DONE does not change the grant unless the pointer order selects it. The record must not change while valid&&!ready.
  - At most one completion per cycle. Other DONE slots wait; they never return to IDLE without their handshake.
- Simultaneous events in one cycle are independent:
  - dispatch to slot A, completion of slot B, and RUN->DONE of slot C may all occur together.
- Latency: dispatch at edge T -> cmp_valid earliest at T+d (slot in DONE after d RUN cycles), given RR grant and cmp_ready.
- core_busy / core_remaining reflect registered state, updated one edge after the causing handshake.

Test Plan:
- Reset, then dispatch d=3 tag=5 prio=2 with cmp_ready=1 -> disp_core=0; core_remaining[0] reads 3,2,1; cmp_valid high 3 cycles after handshake with cmp_core=0, tag=5, prio=2; slot 0 IDLE next cycle; done_count=1.
- Dispatch d=0 tag=1 -> behaves as d=1: cmp_valid one cycle after handshake.
- Fill all 4 slots with d=10 -> disp_ready=0 from the cycle after the 4th handshake; descriptor held on disp_valid is not consumed until a slot returns to IDLE.
- All 4 slots finish in the same cycle with cmp_ready=1 -> completions in order 0,1,2,3 on consecutive cycles. Repeat after the pointer is at 2 -> order 2,3,0,1.
- cmp_ready=0 for 5 cycles while slot 1 is DONE and slot 2 finishes -> cmp_core stays 1 with tag stable; done_count unchanged; on cmp_ready=1, slot 1 then slot 2 complete.
- Assert reset mid-run with 2 slots RUN and 1 DONE -> cmp_valid=0, core_busy=0, done_count=0 immediately (asynchronous); no stale completion after reset release.
